vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern source: colour bars, checkerboard, gradient, bouncing box
// Bouncing box (mode 3) is built only when PATGEN_BOUNCE_EN is defined; otherwise mode 3 is black.
module vga_pattern_gen (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [9:0] iX,
   input  logic [9:0] iY,
   input  logic       iNext,
   output logic [9:0] oRed,
   output logic [9:0] oGreen,
   output logic [9:0] oBlue,
   output logic [1:0] oMode,
   output logic       oFrame_Tick
);
   localparam logic [9:0] X_LAST = 10'd799;
   localparam logic [9:0] Y_LAST = 10'd524;
   localparam logic [9:0] FULL   = 10'h3FF;

   logic [9:0] nx, ny;
   logic       tickCond;
   logic       nextQ, nextEdge, pending;
   logic [1:0] modeNext;
   logic [2:0] bar;
   logic [9:0] red, green, blue;

   // Look-ahead: colour is registered for the pixel the controller samples next cycle
   always_comb begin
      tickCond = (iX == X_LAST) && (iY == Y_LAST);
      nx = iX + 10'd1;
      ny = iY;
      if (iX == X_LAST) begin
         nx = 10'd0;
         ny = (iY == Y_LAST) ? 10'd0 : iY + 10'd1;
      end
      bar = 3'(nx / 10'd80);
   end

   assign nextEdge = iNext & ~nextQ;
   assign modeNext = (tickCond && pending) ? oMode + 2'd1 : oMode;

`ifdef PATGEN_BOUNCE_EN
   logic [9:0] bx, by, bxNext, byNext;
   logic       dx, dy, dxNext, dyNext;
   logic       inBox;

   // Returns {dir, pos}; reflects at 0 and at lim
   function automatic logic [10:0] stepAxis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lim);
      if (dir)
         return (pos >= lim) ? {1'b0, lim - 10'd1} : {1'b1, pos + 10'd1};
      else
         return (pos == 10'd0) ? {1'b1, 10'd1} : {1'b0, pos - 10'd1};
   endfunction

   always_comb begin
      {dxNext, bxNext} = {dx, bx};
      {dyNext, byNext} = {dy, by};
      if (tickCond) begin
         {dxNext, bxNext} = stepAxis(bx, dx, 10'd608);
         {dyNext, byNext} = stepAxis(by, dy, 10'd448);
      end
      inBox = ({1'b0, nx} >= {1'b0, bxNext}) && ({1'b0, nx} < {1'b0, bxNext} + 11'd32) &&
              ({1'b0, ny} >= {1'b0, byNext}) && ({1'b0, ny} < {1'b0, byNext} + 11'd32);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         bx <= 10'd0;
         by <= 10'd0;
         dx <= 1'b1;
         dy <= 1'b1;
      end else begin
         bx <= bxNext;
         by <= byNext;
         dx <= dxNext;
         dy <= dyNext;
      end
   end
`endif

   // Render with next-state mode/box so the first pixel of a frame already matches oMode
   always_comb begin
      red   = 10'd0;
      green = 10'd0;
      blue  = 10'd0;
      if (nx < 10'd640 && ny < 10'd480) begin
         case (modeNext)
            2'd0: begin
               red   = bar[2] ? FULL : 10'd0;
               green = bar[1] ? FULL : 10'd0;
               blue  = bar[0] ? FULL : 10'd0;
            end
            2'd1: begin
               if (nx[5] ^ ny[5]) begin
                  red   = FULL;
                  green = FULL;
                  blue  = FULL;
               end
            end
            2'd2: begin
               red   = nx;
               green = ny;
            end
            default: begin
`ifdef PATGEN_BOUNCE_EN
               if (inBox) begin
                  red   = FULL;
                  green = FULL;
                  blue  = FULL;
               end else begin
                  blue  = 10'h200;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oRed        <= 10'd0;
         oGreen      <= 10'd0;
         oBlue       <= 10'd0;
         oMode       <= 2'd0;
         oFrame_Tick <= 1'b0;
         nextQ       <= 1'b0;
         pending     <= 1'b0;
      end else begin
         oRed        <= red;
         oGreen      <= green;
         oBlue       <= blue;
         oMode       <= modeNext;
         oFrame_Tick <= tickCond;
         nextQ       <= iNext;
         // An edge landing on the tick itself is held for the following frame
         if (tickCond)
            pending <= nextEdge;
         else if (nextEdge)
            pending <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed self-checking bench for vga_pattern_gen
// Box checks run only when PATGEN_BOUNCE_EN is defined.
module tb_vga_pattern_gen;
   logic       iCLK = 1'b0;
   logic       iRST = 1'b1;
   logic [9:0] iX = 10'd0;
   logic [9:0] iY = 10'd0;
   logic       iNext = 1'b0;
   logic [9:0] oRed, oGreen, oBlue;
   logic [1:0] oMode;
   logic       oFrame_Tick;
   int         nCmp = 0;
   int         nBad = 0;

   vga_pattern_gen dut (
      .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iNext(iNext),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oMode(oMode), .oFrame_Tick(oFrame_Tick)
   );

   always #5 iCLK = ~iCLK;

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkRgb(input string tag, input logic [9:0] r, input logic [9:0] g,
                         input logic [9:0] b);
      chk({tag, ".R"}, 32'(oRed), 32'(r));
      chk({tag, ".G"}, 32'(oGreen), 32'(g));
      chk({tag, ".B"}, 32'(oBlue), 32'(b));
   endtask

   task automatic drive(input logic [9:0] x, input logic [9:0] y);
      iX = x;
      iY = y;
      step();
   endtask

   task automatic tick(input logic nxt);
      iNext = nxt;
      drive(10'd799, 10'd524);
   endtask

   task automatic pulse();
      iX = 10'd10;
      iY = 10'd10;
      iNext = 1'b1;
      step();
      iNext = 1'b0;
      step();
   endtask

   initial begin
      #2;
      chkRgb("reset_rgb", 10'd0, 10'd0, 10'd0);
      chk("reset_mode", 32'(oMode), 32'd0);
      chk("reset_tick", 32'(oFrame_Tick), 32'd0);
      step();
      iRST = 1'b0;

      // Mode 0 colour bars
      drive(10'd0, 10'd0);     chkRgb("m0_nx1", 10'd0, 10'd0, 10'd0);
      drive(10'd159, 10'd10);  chkRgb("m0_bar2", 10'd0, 10'h3FF, 10'd0);
      drive(10'd559, 10'd200); chkRgb("m0_bar7", 10'h3FF, 10'h3FF, 10'h3FF);
      drive(10'd399, 10'd200); chkRgb("m0_bar5", 10'h3FF, 10'd0, 10'h3FF);
      drive(10'd639, 10'd100); chkRgb("m0_nx640", 10'd0, 10'd0, 10'd0);
      drive(10'd799, 10'd479); chkRgb("m0_ny480", 10'd0, 10'd0, 10'd0);
      chk("no_tick_479", 32'(oFrame_Tick), 32'd0);
      drive(10'd1023, 10'd1000); chkRgb("oor_a", 10'd0, 10'd0, 10'd0);
      drive(10'd900, 10'd5);     chkRgb("oor_b", 10'd0, 10'd0, 10'd0);

      // Three edges in one frame collapse into one advance
      pulse(); pulse(); pulse();
      chk("mode_hold", 32'(oMode), 32'd0);
      tick(1'b0);
      chk("tick_hi", 32'(oFrame_Tick), 32'd1);
      chk("mode_1", 32'(oMode), 32'd1);
      chkRgb("m1_origin", 10'd0, 10'd0, 10'd0);
      drive(10'd31, 10'd0);
      chk("tick_lo", 32'(oFrame_Tick), 32'd0);
      chkRgb("m1_white", 10'h3FF, 10'h3FF, 10'h3FF);
      drive(10'd31, 10'd32);   chkRgb("m1_black", 10'd0, 10'd0, 10'd0);
      tick(1'b0);
      chk("mode_1_keep", 32'(oMode), 32'd1);

      // Mode 2 gradient
      pulse();
      tick(1'b0);
      chk("mode_2", 32'(oMode), 32'd2);
      drive(10'd99, 10'd50);   chkRgb("m2_grad", 10'd100, 10'd50, 10'd0);
      drive(10'd798, 10'd50);  chkRgb("m2_blank", 10'd0, 10'd0, 10'd0);

      // Reset with an advance pending
      pulse();
      iRST = 1'b1;
      #1;
      chk("rst_mode", 32'(oMode), 32'd0);
      chkRgb("rst_rgb", 10'd0, 10'd0, 10'd0);
      step();
      iRST = 1'b0;
      tick(1'b0);
      chk("rst_no_adv", 32'(oMode), 32'd0);

      // Edge coinciding with the tick applies at the following tick
      drive(10'd0, 10'd0);
      tick(1'b1);
      chk("coinc_hold", 32'(oMode), 32'd0);
      iNext = 1'b0;
      drive(10'd0, 10'd0);
      tick(1'b0);
      chk("coinc_adv", 32'(oMode), 32'd1);
      pulse(); tick(1'b0);
      pulse(); tick(1'b0);
      chk("mode_3", 32'(oMode), 32'd3);
`ifndef PATGEN_BOUNCE_EN
      chkRgb("m3_origin", 10'd0, 10'd0, 10'd0);
      drive(10'd300, 10'd200); chkRgb("m3_mid", 10'd0, 10'd0, 10'd0);
      drive(10'd10, 10'd470);  chkRgb("m3_low", 10'd0, 10'd0, 10'd0);
`endif
      pulse(); tick(1'b0);
      chk("mode_wrap", 32'(oMode), 32'd0);
      drive(10'd559, 10'd5);   chkRgb("wrap_bar7", 10'h3FF, 10'h3FF, 10'h3FF);

`ifdef PATGEN_BOUNCE_EN
      // Box bounce: frames 1..3 are the mode advances, then run to frame 609
      iRST = 1'b1;
      step();
      iRST = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         pulse();
         tick(1'b0);
      end
      chk("box_mode3", 32'(oMode), 32'd3);
      for (int f = 4; f <= 609; f++) begin
         tick(1'b0);
         if (f == 448) begin
            drive(10'd447, 10'd448); chkRgb("f448_in", 10'h3FF, 10'h3FF, 10'h3FF);
            drive(10'd447, 10'd447); chkRgb("f448_out", 10'd0, 10'd0, 10'h200);
         end else if (f == 449) begin
            drive(10'd448, 10'd447); chkRgb("f449_in", 10'h3FF, 10'h3FF, 10'h3FF);
            drive(10'd448, 10'd479); chkRgb("f449_out", 10'd0, 10'd0, 10'h200);
         end else if (f == 608) begin
            drive(10'd607, 10'd288); chkRgb("f608_in", 10'h3FF, 10'h3FF, 10'h3FF);
            drive(10'd606, 10'd288); chkRgb("f608_out", 10'd0, 10'd0, 10'h200);
            drive(10'd638, 10'd319); chkRgb("f608_edge", 10'h3FF, 10'h3FF, 10'h3FF);
         end else if (f == 609) begin
            drive(10'd606, 10'd287); chkRgb("f609_in", 10'h3FF, 10'h3FF, 10'h3FF);
            drive(10'd638, 10'd287); chkRgb("f609_out", 10'd0, 10'd0, 10'h200);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
